// File: rtl/board_load_if.sv
// Board loader bus: decoded FEN square stream and side fields in,
// committed board image and status out.
interface board_load_if;
  logic         in_pos_valid;
  logic [3:0]   in_pos_data;
  logic         in_pos_sop;
  logic         in_pos_eop;
  logic         in_wtp;
  logic [3:0]   in_castle;
  logic [2:0]   in_ep;
  logic [15:0]  in_hmcount;
  logic [15:0]  in_fmcount;
  logic [255:0] o_board;
  logic         o_wtp;
  logic [3:0]   o_castle;
  logic [2:0]   o_ep;
  logic [15:0]  o_hmcount;
  logic [15:0]  o_fmcount;
  logic [5:0]   o_wking_sq;
  logic [5:0]   o_bking_sq;
  logic         o_valid;
  logic         o_error;
  logic [2:0]   o_err_code;

  modport master (
    output in_pos_valid, in_pos_data,
    output in_pos_sop, in_pos_eop,
    output in_wtp, in_castle, in_ep,
    output in_hmcount, in_fmcount,
    input  o_board, o_wtp, o_castle, o_ep,
    input  o_hmcount, o_fmcount,
    input  o_wking_sq, o_bking_sq,
    input  o_valid, o_error, o_err_code
  );

  modport slave (
    input  in_pos_valid, in_pos_data,
    input  in_pos_sop, in_pos_eop,
    input  in_wtp, in_castle, in_ep,
    input  in_hmcount, in_fmcount,
    output o_board, o_wtp, o_castle, o_ep,
    output o_hmcount, o_fmcount,
    output o_wking_sq, o_bking_sq,
    output o_valid, o_error, o_err_code
  );
endinterface

// File: rtl/board_load.sv
// Loads one FEN square stream into a shadow board, validates it and
// commits it atomically to the board bus read by the move generator.
module board_load (
  input  logic       clk,
  input  logic       rst_n,
  board_load_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CHECK = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [255:0] shd_q, shd_d;
  logic [6:0]   cnt_q, cnt_d;
  logic [1:0]   wk_q, wk_d;
  logic [1:0]   bk_q, bk_d;
  logic         ill_q, ill_d;
  logic         ovf_q, ovf_d;
  logic [5:0]   swk_q, swk_d;
  logic [5:0]   sbk_q, sbk_d;
  logic         swtp_q, swtp_d;
  logic [3:0]   scas_q, scas_d;
  logic [2:0]   sep_q, sep_d;
  logic [15:0]  shm_q, shm_d;
  logic [15:0]  sfm_q, sfm_d;

  logic [255:0] brd_q, brd_d;
  logic         wtp_q, wtp_d;
  logic [3:0]   cas_q, cas_d;
  logic [2:0]   ep_q, ep_d;
  logic [15:0]  hm_q, hm_d;
  logic [15:0]  fm_q, fm_d;
  logic [5:0]   wks_q, wks_d;
  logic [5:0]   bks_q, bks_d;
  logic         vld_q, vld_d;
  logic         err_q, err_d;
  logic [2:0]   code_q, code_d;

  logic         sop;
  logic         eop;
  logic         accept;
  logic [6:0]   idx;
  logic         wr;
  logic [5:0]   sq;
  logic [2:0]   piece;
  logic         edge_rank;
  logic         bad;
  logic [2:0]   err;

  assign sop    = bus.in_pos_valid & bus.in_pos_sop;
  assign eop    = bus.in_pos_valid & bus.in_pos_eop;
  assign accept = bus.in_pos_valid &
                  ((state_q == IDLE & bus.in_pos_sop) |
                   (state_q == LOAD));
  assign idx    = sop ? 7'd0 : cnt_q;
  assign wr     = accept & ~idx[6];
  // FEN walks a8..h8 first, so the rank field is inverted
  assign sq     = {~idx[5:3], idx[2:0]};
  assign piece  = bus.in_pos_data[2:0];
  assign edge_rank = (sq[5:3] == 3'd0) | (sq[5:3] == 3'd7);
  assign bad    = (piece == 3'b111) |
                  ((piece == 3'b110) & edge_rank);

  assign err = {ill_q,
                (wk_q != 2'd1) | (bk_q != 2'd1),
                (cnt_q != 7'd64) | ovf_q};

  // shadow datapath
  always_comb begin
    shd_d  = shd_q;
    cnt_d  = cnt_q;
    wk_d   = wk_q;
    bk_d   = bk_q;
    ill_d  = ill_q;
    ovf_d  = ovf_q;
    swk_d  = swk_q;
    sbk_d  = sbk_q;
    swtp_d = swtp_q;
    scas_d = scas_q;
    sep_d  = sep_q;
    shm_d  = shm_q;
    sfm_d  = sfm_q;
    if (accept) begin
      if (sop) begin
        wk_d  = 2'd0;
        bk_d  = 2'd0;
        ill_d = 1'b0;
        ovf_d = 1'b0;
      end
      cnt_d = (idx == 7'd127) ? 7'd127 : idx + 7'd1;
      if (idx[6]) ovf_d = 1'b1;
      if (wr) begin
        shd_d[{sq, 2'b00} +: 4] = bus.in_pos_data;
        if (bus.in_pos_data == 4'b1001) begin
          wk_d  = (wk_d == 2'd2) ? 2'd2 : wk_d + 2'd1;
          swk_d = sq;
        end
        if (bus.in_pos_data == 4'b0001) begin
          bk_d  = (bk_d == 2'd2) ? 2'd2 : bk_d + 2'd1;
          sbk_d = sq;
        end
        if (bad) ill_d = 1'b1;
      end
      if (eop) begin
        swtp_d = bus.in_wtp;
        scas_d = bus.in_castle;
        sep_d  = bus.in_ep;
        shm_d  = bus.in_hmcount;
        sfm_d  = bus.in_fmcount;
      end
    end
  end

  // next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = eop ? CHECK : LOAD;
      LOAD:    if (eop) state_d = CHECK;
      CHECK:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // committed outputs
  always_comb begin
    brd_d  = brd_q;
    wtp_d  = wtp_q;
    cas_d  = cas_q;
    ep_d   = ep_q;
    hm_d   = hm_q;
    fm_d   = fm_q;
    wks_d  = wks_q;
    bks_d  = bks_q;
    code_d = code_q;
    vld_d  = 1'b0;
    err_d  = 1'b0;
    if (state_q == CHECK) begin
      code_d = err;
      if (err == 3'b000) begin
        brd_d = shd_q;
        wtp_d = swtp_q;
        cas_d = scas_q;
        ep_d  = sep_q;
        hm_d  = shm_q;
        fm_d  = sfm_q;
        wks_d = swk_q;
        bks_d = sbk_q;
        vld_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shd_q   <= '0;
      cnt_q   <= '0;
      wk_q    <= '0;
      bk_q    <= '0;
      ill_q   <= 1'b0;
      ovf_q   <= 1'b0;
      swk_q   <= '0;
      sbk_q   <= '0;
      swtp_q  <= 1'b0;
      scas_q  <= '0;
      sep_q   <= '0;
      shm_q   <= '0;
      sfm_q   <= '0;
    end else begin
      state_q <= state_d;
      shd_q   <= shd_d;
      cnt_q   <= cnt_d;
      wk_q    <= wk_d;
      bk_q    <= bk_d;
      ill_q   <= ill_d;
      ovf_q   <= ovf_d;
      swk_q   <= swk_d;
      sbk_q   <= sbk_d;
      swtp_q  <= swtp_d;
      scas_q  <= scas_d;
      sep_q   <= sep_d;
      shm_q   <= shm_d;
      sfm_q   <= sfm_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      brd_q  <= '0;
      wtp_q  <= 1'b0;
      cas_q  <= '0;
      ep_q   <= '0;
      hm_q   <= '0;
      fm_q   <= '0;
      wks_q  <= 6'd4;
      bks_q  <= 6'd60;
      vld_q  <= 1'b0;
      err_q  <= 1'b0;
      code_q <= '0;
    end else begin
      brd_q  <= brd_d;
      wtp_q  <= wtp_d;
      cas_q  <= cas_d;
      ep_q   <= ep_d;
      hm_q   <= hm_d;
      fm_q   <= fm_d;
      wks_q  <= wks_d;
      bks_q  <= bks_d;
      vld_q  <= vld_d;
      err_q  <= err_d;
      code_q <= code_d;
    end
  end

  assign bus.o_board    = brd_q;
  assign bus.o_wtp      = wtp_q;
  assign bus.o_castle   = cas_q;
  assign bus.o_ep       = ep_q;
  assign bus.o_hmcount  = hm_q;
  assign bus.o_fmcount  = fm_q;
  assign bus.o_wking_sq = wks_q;
  assign bus.o_bking_sq = bks_q;
  assign bus.o_valid    = vld_q;
  assign bus.o_error    = err_q;
  assign bus.o_err_code = code_q;

endmodule

// File: tb/tb_board_load.sv
// Directed bench for board_load: legal commits, rejections,
// restart, reset mid-packet and stray beats.
module tb_board_load;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  board_load_if bus ();

  board_load dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int vcnt = 0;
  int ecnt = 0;
  int v0, e0;

  logic [3:0]   cur [64];
  logic [255:0] start_img;
  logic [255:0] pos2_img;

  always @(posedge clk) begin
    if (bus.o_valid) vcnt <= vcnt + 1;
    if (bus.o_error) ecnt <= ecnt + 1;
  end

  task automatic chk(input string tag,
                     input logic [255:0] obs,
                     input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] cur_img();
    logic [255:0] b;
    logic [5:0] ix;
    int s;
    b = '0;
    for (int i = 0; i < 64; i++) begin
      ix = i[5:0];
      s = {26'd0, ~ix[5:3], ix[2:0]};
      b[s*4 +: 4] = cur[i];
    end
    return b;
  endfunction

  task automatic load_start();
    logic [3:0] r8 [8];
    logic [3:0] r1 [8];
    r8 = '{4'h3, 4'h5, 4'h4, 4'h2, 4'h1, 4'h4, 4'h5, 4'h3};
    r1 = '{4'hB, 4'hD, 4'hC, 4'hA, 4'h9, 4'hC, 4'hD, 4'hB};
    for (int i = 0; i < 64; i++) cur[i] = 4'h0;
    for (int f = 0; f < 8; f++) begin
      cur[f]      = r8[f];
      cur[8 + f]  = 4'h6;
      cur[48 + f] = 4'hE;
      cur[56 + f] = r1[f];
    end
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_pos_valid = 1'b0;
    bus.in_pos_sop   = 1'b0;
    bus.in_pos_eop   = 1'b0;
  endtask

  task automatic send(input int n, input bit sop_en,
                      input bit eop_en);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.in_pos_valid = 1'b1;
      bus.in_pos_data  = cur[i % 64];
      bus.in_pos_sop   = sop_en && (i == 0);
      bus.in_pos_eop   = eop_en && (i == n - 1);
    end
    idle();
  endtask

  task automatic result(input string tag, input bit ev,
                        input bit ee, input logic [2:0] code);
    chk({tag, "_early"}, {bus.o_valid, bus.o_error}, 2'b00);
    @(negedge clk);
    chk({tag, "_valid"}, bus.o_valid, ev);
    chk({tag, "_error"}, bus.o_error, ee);
    chk({tag, "_code"}, bus.o_err_code, code);
    @(negedge clk);
    chk({tag, "_drop"}, {bus.o_valid, bus.o_error}, 2'b00);
  endtask

  initial begin
    bus.in_pos_valid = 1'b0;
    bus.in_pos_data  = 4'h0;
    bus.in_pos_sop   = 1'b0;
    bus.in_pos_eop   = 1'b0;
    bus.in_wtp       = 1'b1;
    bus.in_castle    = 4'hF;
    bus.in_ep        = 3'd0;
    bus.in_hmcount   = 16'd0;
    bus.in_fmcount   = 16'd1;

    #12;
    chk("rst_board", bus.o_board, '0);
    chk("rst_wk", bus.o_wking_sq, 6'd4);
    chk("rst_bk", bus.o_bking_sq, 6'd60);
    chk("rst_pulse", {bus.o_valid, bus.o_error}, 2'b00);
    chk("rst_code", bus.o_err_code, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;

    // start position
    load_start();
    start_img = cur_img();
    send(64, 1'b1, 1'b1);
    result("start", 1'b1, 1'b0, 3'b000);
    chk("start_board", bus.o_board, start_img);
    chk("a1", bus.o_board[0*4 +: 4], 4'hB);
    chk("e1", bus.o_board[4*4 +: 4], 4'h9);
    chk("e8", bus.o_board[60*4 +: 4], 4'h1);
    chk("e2", bus.o_board[12*4 +: 4], 4'hE);
    chk("e4", bus.o_board[28*4 +: 4], 4'h0);
    chk("wk_sq", bus.o_wking_sq, 6'd4);
    chk("bk_sq", bus.o_bking_sq, 6'd60);
    chk("wtp", bus.o_wtp, 1'b1);
    chk("castle", bus.o_castle, 4'hF);
    chk("fm", bus.o_fmcount, 16'd1);

    // short and long packets
    bus.in_castle = 4'h3;
    send(63, 1'b1, 1'b1);
    result("n63", 1'b0, 1'b1, 3'b001);
    chk("n63_board", bus.o_board, start_img);
    chk("n63_castle", bus.o_castle, 4'hF);
    send(65, 1'b1, 1'b1);
    result("n65", 1'b0, 1'b1, 3'b001);
    chk("n65_board", bus.o_board, start_img);
    bus.in_castle = 4'hF;

    // king errors
    cur[4] = 4'h9;
    send(64, 1'b1, 1'b1);
    result("two_wk", 1'b0, 1'b1, 3'b010);
    cur[4] = 4'h0;
    send(64, 1'b1, 1'b1);
    result("no_bk", 1'b0, 1'b1, 3'b010);
    load_start();

    // illegal squares
    cur[0] = 4'hE;
    send(64, 1'b1, 1'b1);
    result("pawn_a8", 1'b0, 1'b1, 3'b100);
    load_start();
    cur[20] = 4'h7;
    send(64, 1'b1, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("code7_bit2", bus.o_err_code[2], 1'b1);
    chk("code7_board", bus.o_board, start_img);

    // restart after 20 beats, then 1.e4 position
    load_start();
    v0 = vcnt;
    send(20, 1'b1, 1'b0);
    cur[52] = 4'h0;
    cur[36] = 4'hE;
    pos2_img = cur_img();
    bus.in_wtp = 1'b0;
    bus.in_ep  = 3'd4;
    send(64, 1'b1, 1'b1);
    result("restart", 1'b1, 1'b0, 3'b000);
    chk("restart_once", vcnt - v0, 1);
    chk("restart_board", bus.o_board, pos2_img);
    chk("restart_e4", bus.o_board[28*4 +: 4], 4'hE);
    chk("restart_e2", bus.o_board[12*4 +: 4], 4'h0);
    chk("restart_wtp", bus.o_wtp, 1'b0);
    chk("restart_ep", bus.o_ep, 3'd4);

    // sop+eop single beat
    cur[0] = 4'h0;
    send(1, 1'b1, 1'b1);
    result("single", 1'b0, 1'b1, 3'b011);
    chk("single_board", bus.o_board, pos2_img);

    // reset mid-packet
    load_start();
    v0 = vcnt;
    e0 = ecnt;
    send(30, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_board", bus.o_board, '0);
    chk("mid_rst_wk", bus.o_wking_sq, 6'd4);
    chk("mid_rst_bk", bus.o_bking_sq, 6'd60);
    chk("mid_rst_code", bus.o_err_code, 3'b000);
    chk("mid_rst_ep", bus.o_ep, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("mid_rst_nopulse", {vcnt - v0, ecnt - e0}, 64'd0);
    bus.in_wtp = 1'b1;
    bus.in_ep  = 3'd0;
    send(64, 1'b1, 1'b1);
    result("post_rst", 1'b1, 1'b0, 3'b000);
    chk("post_rst_board", bus.o_board, start_img);

    // stray beats with no sop
    v0 = vcnt;
    e0 = ecnt;
    for (int i = 0; i < 64; i++) cur[i] = 4'h0;
    send(10, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    chk("stray_nopulse", {vcnt - v0, ecnt - e0}, 64'd0);
    chk("stray_board", bus.o_board, start_img);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/board_load.md
# board_load

Loads one decoded FEN position into a registered 64-square board image. Consumes the square stream and side fields produced by the FEN decoder and validates square count, kings and pawn placement. Commits the result atomically to the board bus read by the move generator. Every completed packet produces either a one-cycle `o_valid` (board updated) or a one-cycle `o_error` (board unchanged).

## Interface
Parameters:
- none

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_pos_valid` in 1: square beat valid.
- `in_pos_data` in 4: `{white, piece[2:0]}`. Piece codes: 000 none, 001 king, 010 queen, 011 rook, 100 bishop, 101 knight, 110 pawn, 111 forbidden.
- `in_pos_sop` in 1: first square, a8. Qualified by `in_pos_valid`.
- `in_pos_eop` in 1: last square. Qualified by `in_pos_valid`.
- `in_wtp`, `in_castle[3:0]`, `in_ep[2:0]`, `in_hmcount[15:0]`, `in_fmcount[15:0]` in: side fields. Stable while the stream is active.
- `o_board` out 256: square `sq` occupies `o_board[sq*4 +: 4]`; a1 = 0, h1 = 7, a8 = 56.
- `o_wtp`, `o_castle[3:0]`, `o_ep[2:0]`, `o_hmcount[15:0]`, `o_fmcount[15:0]` out: committed side fields.
- `o_wking_sq` out 6: square of the white king.
- `o_bking_sq` out 6: square of the black king.
- `o_valid` out 1: one-cycle pulse; new board committed.
- `o_error` out 1: one-cycle pulse; packet rejected.
- `o_err_code` out 3: bit0 count≠64, bit1 king count≠1 for either colour, bit2 illegal square (code 111, or pawn on rank 1/8). Held until the next `o_valid` or `o_error`.

## Operation
States: IDLE, LOAD, CHECK.

IDLE
- Beats without `in_pos_sop` are ignored.
- A valid `in_pos_sop` beat writes square index 0, sets count = 1, clears the per-packet flags, and goes to LOAD.
- If the same beat also has `in_pos_eop`, go directly to CHECK.

LOAD
- Each valid beat writes the shadow board at `sq = {~idx[5:3], idx[2:0]}` (FEN order a8..h8, a7..h1) and increments idx and count.
- Count saturates at 127. Beats with idx ≥ 64 are not written and set the overflow flag.
- A valid `in_pos_sop` in LOAD restarts the packet: idx = 0, flags cleared, the beat is written as index 0.
- A valid `in_pos_eop` beat is written normally, the side fields are sampled into shadow registers, and the state goes to CHECK.

Per-beat checks, on written beats only:
- White king: data = 4'b1001. Black king: data = 4'b0001. Each king counter is 2 bits and saturates at 2. The king's square is latched into the shadow king register.
- Illegal flag: piece = 111, or piece = 110 with rank 0 or rank 7.

CHECK (one cycle)
- err = `{illegal, wk≠1 | bk≠1, count≠64}`.
- err = 0: copy the shadow board, side fields and king squares to the outputs; pulse `o_valid`.
- Otherwise: outputs unchanged; pulse `o_error`; load `o_err_code`.
- Return to IDLE.
- Beats arriving during CHECK are ignored, including sop. The upstream stage guarantees at least one idle cycle between packets.

Reset values (`rst_n` low, asynchronous):
- `o_board` = 0 (all empty).
- All side outputs = 0.
- `o_wking_sq` = 4, `o_bking_sq` = 60.
- `o_valid` = 0, `o_error` = 0, `o_err_code` = 0.
- State = IDLE. Shadow board and counters cleared.
- Reset during LOAD discards the packet with no pulse.

## Timing
- Eop beat sampled at edge N. CHECK occupies cycle N..N+1. `o_valid` or `o_error` is high for exactly the cycle following edge N+1; committed outputs change at edge N+1.
- Latency from the eop beat to visible board: 2 edges.
- A full 64-beat packet occupies 66 cycles from sop to the end of the pulse.
- No backpressure; the block accepts one beat per cycle unconditionally.
- `o_board` never shows a partial packet.

## Test plan
- **Start position stream, wtp = 1, castle = 4'hF, fm = 1:** `o_valid` 2 cycles after eop. a1 nibble = 4'hB, e1 = 4'h9, e8 = 4'h1, e2 = 4'hE, e4 = 4'h0. `o_wking_sq` = 4, `o_bking_sq` = 60. `o_castle` = 4'hF, `o_fmcount` = 1.
- **63-beat packet with kings present:** `o_error`, `o_err_code` = 3'b001, `o_board` still equal to the previous start position. **Same packet with 65 beats:** `o_err_code` = 3'b001.
- **Two white kings, or no black king:** `o_err_code` = 3'b010. **White pawn (4'hE) at index 0 (a8):** `o_err_code` = 3'b100. **Data 4'h7 anywhere:** bit2 set.
- **Second sop after 20 beats, then a full legal 64-beat packet:** single `o_valid`; board reflects the second packet only. **Single beat with sop + eop:** `o_error`, code 3'b011.
- **`rst_n` low mid-LOAD at beat 30:** outputs at reset values immediately (asynchronous); no pulse. A following legal packet commits normally.
- **Beats without a preceding sop in IDLE:** ignored; no pulse, board unchanged.
